// File: rtl/sram_block_ctrl.sv
// Sequencer for one sram_block: zero-fills the array after reset, then arbitrates one writer and
// NUM_RD readers for the single access slot. Define SRAM_CTRL_RR_EN for round-robin reader grant.
`ifndef LIM_BRICK_WORD_SIZE
`define LIM_BRICK_WORD_SIZE 8
`endif
`ifndef LIM_BRICK_WORD_NUM
`define LIM_BRICK_WORD_NUM 16
`endif

module sram_block_ctrl #(
   parameter int unsigned NUM_BRICKS = 4,
   parameter int unsigned BL_WIDTH   = `LIM_BRICK_WORD_SIZE,
   parameter int unsigned WL_WIDTH   = `LIM_BRICK_WORD_NUM,
   parameter int unsigned NUM_RD     = 2,
   localparam int unsigned DEPTH     = NUM_BRICKS * WL_WIDTH,
   localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned WLT       = NUM_BRICKS * WL_WIDTH
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         WR_VALID,
   output logic                         WR_READY,
   input  logic [AW-1:0]                WR_ADDR,
   input  logic [BL_WIDTH-1:0]          WR_DATA,
   input  logic [NUM_RD-1:0]            RD_VALID,
   output logic [NUM_RD-1:0]            RD_READY,
   input  logic [NUM_RD*AW-1:0]         RD_ADDR,
   output logic [NUM_RD-1:0]            RSP_VALID,
   input  logic [NUM_RD-1:0]            RSP_READY,
   output logic [NUM_RD*BL_WIDTH-1:0]   RSP_DATA,
   output logic                         INIT_DONE,
   output logic [NUM_BRICKS-1:0]        BLK_RE,
   output logic [WLT-1:0]               DRWL,
   output logic [WLT-1:0]               DWWL,
   output logic [BL_WIDTH-1:0]          WBL,
   input  logic [BL_WIDTH-1:0]          ARBL
);

   localparam int unsigned WlBits  = $clog2(WL_WIDTH);
   localparam int unsigned RdIdxW  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
   localparam logic [AW:0] DepthExt = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] IcLast = AW'(DEPTH - 1);

   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e                       state_q, state_d;
   logic [AW-1:0]                ic_q, ic_d;
   logic                         init_done_q, init_done_d;
   logic [NUM_BRICKS-1:0]        blk_re_q, blk_re_d;
   logic [WLT-1:0]               drwl_q, drwl_d, dwwl_q, dwwl_d;
   logic [BL_WIDTH-1:0]          wbl_q, wbl_d;
   logic [NUM_RD-1:0]            iss_rd_q, iss_rd_d;
   logic                         iss_oor_q, iss_oor_d;
   logic [NUM_RD-1:0]            rsp_valid_q, rsp_valid_d;
   logic [NUM_RD*BL_WIDTH-1:0]   rsp_data_q, rsp_data_d;

   logic [NUM_RD-1:0]            rd_elig, rd_grant;
   logic [RdIdxW-1:0]            rd_sel;
   logic                         rd_any, wr_acc, wr_in_rng, rd_in_rng;
   logic [AW-1:0]                rd_addr;

   assign wr_acc    = init_done_q & WR_VALID;
   assign wr_in_rng = {1'b0, WR_ADDR} < DepthExt;
   assign rd_addr   = RD_ADDR[AW*rd_sel +: AW];
   assign rd_in_rng = {1'b0, rd_addr} < DepthExt;

`ifdef SRAM_CTRL_RR_EN
   logic [RdIdxW-1:0] rr_ptr_q, rr_ptr_d;
   logic [RdIdxW-1:0] rr_idx;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (rd_any) begin
         rr_ptr_d = (rd_sel == RdIdxW'(NUM_RD - 1)) ? '0 : rd_sel + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) rr_ptr_q <= '0;
      else     rr_ptr_q <= rr_ptr_d;
   end
`endif

   // A reader may be granted only if its response slot is free by the accept edge.
   always_comb begin
      rd_elig = '0;
      rd_sel  = '0;
      rd_any  = 1'b0;
`ifdef SRAM_CTRL_RR_EN
      rr_idx  = '0;
`endif
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         rd_elig[i] = RD_VALID[i] & ~iss_rd_q[i] & (~rsp_valid_q[i] | RSP_READY[i]);
      end
      if (init_done_q && !WR_VALID) begin
         for (int unsigned k = 0; k < NUM_RD; k++) begin
`ifdef SRAM_CTRL_RR_EN
            rr_idx = RdIdxW'((32'(rr_ptr_q) + k) % NUM_RD);
            if (!rd_any && rd_elig[rr_idx]) begin
               rd_any = 1'b1;
               rd_sel = rr_idx;
            end
`else
            if (!rd_any && rd_elig[k]) begin
               rd_any = 1'b1;
               rd_sel = RdIdxW'(k);
            end
`endif
         end
      end
      rd_grant = rd_any ? (NUM_RD'(1) << rd_sel) : '0;
   end

   always_comb begin
      state_d     = state_q;
      ic_d        = ic_q;
      init_done_d = init_done_q;
      blk_re_d    = '0;
      drwl_d      = '0;
      dwwl_d      = '0;
      wbl_d       = '0;
      iss_rd_d    = '0;
      iss_oor_d   = 1'b0;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      unique case (state_q)
         StInit: begin
            dwwl_d = WLT'(1) << ic_q;
            if (ic_q == IcLast) state_d = StRun;
            else                ic_d    = ic_q + 1'b1;
         end
         StRun: begin
            init_done_d = 1'b1;
            if (wr_acc) begin
               dwwl_d = wr_in_rng ? (WLT'(1) << WR_ADDR) : '0;
               wbl_d  = wr_in_rng ? WR_DATA : '0;
            end else if (rd_any) begin
               drwl_d    = rd_in_rng ? (WLT'(1) << rd_addr) : '0;
               blk_re_d  = rd_in_rng ? (NUM_BRICKS'(1) << (rd_addr >> WlBits)) : '0;
               iss_rd_d  = rd_grant;
               iss_oor_d = ~rd_in_rng;
            end
         end
         default: state_d = StInit;
      endcase
      // Loading a new response takes precedence over consuming the old one.
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         if (iss_rd_q[i]) begin
            rsp_valid_d[i] = 1'b1;
            rsp_data_d[BL_WIDTH*i +: BL_WIDTH] = iss_oor_q ? '0 : ARBL;
         end else if (RSP_READY[i]) begin
            rsp_valid_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= StInit;
         ic_q        <= '0;
         init_done_q <= 1'b0;
         blk_re_q    <= '0;
         drwl_q      <= '0;
         dwwl_q      <= '0;
         wbl_q       <= '0;
         iss_rd_q    <= '0;
         iss_oor_q   <= 1'b0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         ic_q        <= ic_d;
         init_done_q <= init_done_d;
         blk_re_q    <= blk_re_d;
         drwl_q      <= drwl_d;
         dwwl_q      <= dwwl_d;
         wbl_q       <= wbl_d;
         iss_rd_q    <= iss_rd_d;
         iss_oor_q   <= iss_oor_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign WR_READY  = init_done_q;
   assign RD_READY  = rd_grant;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_DATA  = rsp_data_q;
   assign INIT_DONE = init_done_q;
   assign BLK_RE    = blk_re_q;
   assign DRWL      = drwl_q;
   assign DWWL      = dwwl_q;
   assign WBL       = wbl_q;

endmodule
